serial_sub16: RTL and testbench
===============================

Name: serial_sub16

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = a - b, LSB first, through a single full-subtractor cell and a registered borrow.
- Counterpart to the combinational incrementer/adder path in the Hack arithmetic library. It trades WIDTH cycles of latency for one-bit datapath area.
- Operands enter and results leave through valid/ready handshakes. It sits between an operand source (ALU sequencer or testbench driver) and a result sink.

Parameters:
- WIDTH, 16, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  source presents a valid operand pair.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend; sampled only on accept.
- b  input  WIDTH  subtrahend; sampled only on accept.
- out_valid  output  1  result registers hold a valid result; high only in DONE.
- out_ready  input  1  sink accepts the result.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow  output  1  1 iff a < b, unsigned.
- zero  output  1  1 iff diff == 0.
- neg  output  1  diff[WIDTH-1].

Behaviour:
- Reset:
  - Synchronous, active-high, and it overrides everything else, including mid-RUN and mid-DONE.
  - After the reset edge: state=IDLE, in_ready=1, out_valid=0, diff=0, borrow=0, zero=0, neg=0, bit counter=0.
  - Any in-flight operation is discarded with no output.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept when in_valid & in_ready at a rising edge. On that edge:
    - a_sh <= a, b_sh <= b.
    - Borrow register bw <= 0, counter <= 0, diff shift register cleared.
    - State goes to RUN.
  - If in_valid=0, stay in IDLE. Result outputs keep the last result.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge processes bit i = counter:
    - d = a_sh[0] ^ b_sh[0] ^ bw.
    - bw <= (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bw).
    - d is shifted into the diff register MSB side, so after WIDTH shifts bit 0 sits at diff[0].
    - a_sh and b_sh shift right by 1; counter increments.
  - On the edge where counter == WIDTH-1, all of the following happen:
    - The last bit is processed.
    - borrow <= next bw.
    - zero and neg are computed from the final diff value, registered in the same edge.
    - State goes to DONE.
  - Latency: accept edge E0, final bit at edge E_WIDTH. out_valid is high in the cycle after E_WIDTH, i.e. exactly WIDTH cycles after accept.
  - in_valid and a/b changes during RUN are ignored.
  - Intermediate diff bits may be visible while out_valid=0; the sink must not use them.
- DONE:
  - out_valid=1, in_ready=0.
  - diff, borrow, zero and neg are stable and held while out_ready=0, for unlimited backpressure.
  - On an edge with out_ready=1, state goes to IDLE. Outputs keep their values; out_valid drops.
  - A new operand cannot be accepted in the same cycle as result consumption. Minimum initiation interval is WIDTH+2 cycles with out_ready tied high.
- Arithmetic:
  - Unsigned modulo 2^WIDTH. borrow is the final borrow-out.
  - The block provides no signed overflow flag; neg is the raw MSB only.
- Counter width is clog2(WIDTH); it wraps to 0 on the transition to DONE.
- Simultaneous reset with in_valid, or with out_ready: reset wins, and no accept or consume occurs.

Test Plan:
- reset, then a=0x0005, b=0x0003, in_valid 1 cycle, out_ready=1 -> out_valid exactly 16 cycles after accept, diff=0x0002, borrow=0, zero=0, neg=0; IDLE next cycle.
- a=0x0003, b=0x0005 -> diff=0xFFFE, borrow=1, neg=1, zero=0. Then a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1.
- a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, neg=0. Then a=b=0x1234 -> diff=0x0000, zero=1, borrow=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid rises -> diff/flags stable, in_ready=0, new in_valid ignored. out_ready=1 -> one transfer, then in_ready=1.
- Reset asserted at RUN cycle 7 -> next cycle IDLE, in_ready=1, out_valid=0, diff=0, borrow=0. A following 0x00FF-0x000F yields 0x00F0.
- Back-to-back: in_valid and out_ready held high, 4 random operand pairs -> each result matches (a-b) mod 65536, accepts spaced exactly 18 cycles apart, no result lost or duplicated.

Source files
------------

// File: rtl/serial_sub16.sv
// serial_sub16: bit-serial unsigned subtractor diff = a - b, LSB first, with valid/ready handshakes
// Ports: clk, reset (sync, active-high); in_valid/in_ready with operands a, b;
// out_valid/out_ready with results diff, borrow (a < b), zero (diff == 0), neg (diff MSB).
module serial_sub16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             neg
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q, diff_d;
  logic [CW-1:0]    cnt_q;
  logic             bw_q, bw_d, bit_d, borrow_q, zero_q, neg_q, last;
  assign bit_d  = a_q[0] ^ b_q[0] ^ bw_q;
  assign bw_d   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);
  // each result bit enters at the MSB, so after WIDTH shifts bit 0 lands at diff[0]
  assign diff_d = {bit_d, diff_q[WIDTH-1:1]};
  assign last   = cnt_q == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bw_q     <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          bw_q    <= 1'b0;
          cnt_q   <= '0;
          diff_q  <= '0;
          state_q <= RUN;
        end
        RUN: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          bw_q   <= bw_d;
          diff_q <= diff_d;
          cnt_q  <= last ? '0 : cnt_q + CW'(1);
          if (last) begin
            borrow_q <= bw_d;
            zero_q   <= diff_d == '0;
            neg_q    <= bit_d;
            state_q  <= DONE;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
endmodule

// File: tb/tb_serial_sub16.sv
// tb_serial_sub16: scoreboard bench for serial_sub16
module tb_serial_sub16;
  localparam int W = 16;
  typedef struct packed {logic [W-1:0] d; logic bw; logic z; logic n;} exp_t;
  localparam logic [W-1:0] VA [5] = '{16'h0005, 16'h0003, 16'h0000, 16'h8000, 16'h1234};
  localparam logic [W-1:0] VB [5] = '{16'h0003, 16'h0005, 16'h0001, 16'h0001, 16'h1234};
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, borrow, zero, neg;
  logic [W-1:0] a, b, diff;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  serial_sub16 #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .borrow(borrow), .zero(zero), .neg(neg)
  );
  always #5 clk = ~clk;
  task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.d = x - y;
    e.bw = x < y;
    e.z = e.d == '0;
    e.n = e.d[W-1];
    sb.push_back(e);
  endtask
  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input bit keep);
    a = x;
    b = y;
    in_valid = 1'b1;
    if (keep) push_exp(x, y);
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  task automatic test_reset();
    bit seen;
    reset = 1'b1;
    in_valid = 1'b1;
    a = 16'h0005;
    b = 16'h0003;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, diff, borrow, zero, neg} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b diff=%h bw=%b z=%b n=%b want rdy=1 vld=0 diff=0000 flags=0",
               in_ready, out_valid, diff, borrow, zero, neg);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_vs_in_valid: got an accept/result after reset with in_valid, want none");
    end
  endtask
  task automatic test_arith();
    exp_t e;
    int cyc;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL arith%0d_ready: got %b want 1", i, in_ready);
      end
      drive(VA[i], VB[i], 1'b1);
      wait_valid(cyc);
      n_checks++;
      if (cyc != 16) begin
        n_fail++;
        $display("FAIL arith%0d_latency: got %0d cycles want 16", i, cyc);
      end
      e = sb.pop_front();
      n_checks++;
      if ({diff, borrow, zero, neg} !== e) begin
        n_fail++;
        $display("FAIL arith%0d_result %h-%h: got diff=%h bw=%b z=%b n=%b want diff=%h bw=%b z=%b n=%b",
                 i, VA[i], VB[i], diff, borrow, zero, neg, e.d, e.bw, e.z, e.n);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL arith%0d_ready_in_done: got %b want 0", i, in_ready);
      end
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, diff} !== {2'b10, e.d}) begin
        n_fail++;
        $display("FAIL arith%0d_idle_after: got rdy=%b vld=%b diff=%h want rdy=1 vld=0 diff=%h",
                 i, in_ready, out_valid, diff, e.d);
      end
    end
  endtask
  task automatic test_backpressure();
    exp_t e;
    int cyc;
    bit seen;
    out_ready = 1'b0;
    drive(16'h0246, 16'h1357, 1'b1);
    wait_valid(cyc);
    n_checks++;
    if (cyc != 16) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d cycles want 16", cyc);
    end
    e = sb.pop_front();
    in_valid = 1'b1;
    a = 16'hFFFF;
    b = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({out_valid, in_ready, diff, borrow, zero, neg} !== {2'b10, e}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got vld=%b rdy=%b diff=%h bw=%b z=%b n=%b want vld=1 rdy=0 diff=%h bw=%b z=%b n=%b",
                 i, out_valid, in_ready, diff, borrow, zero, neg, e.d, e.bw, e.z, e.n);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready, diff} !== {2'b01, e.d}) begin
      n_fail++;
      $display("FAIL bp_release: got vld=%b rdy=%b diff=%h want vld=0 rdy=1 diff=%h", out_valid, in_ready, diff, e.d);
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL bp_no_extra: got extra out_valid want none");
    end
  endtask
  task automatic test_reset_mid_run();
    exp_t e;
    int cyc;
    bit seen;
    out_ready = 1'b1;
    drive(16'hAAAA, 16'h1111, 1'b0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, diff, borrow, zero, neg} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000}) begin
      n_fail++;
      $display("FAIL midrun_reset: got rdy=%b vld=%b diff=%h bw=%b z=%b n=%b want rdy=1 vld=0 diff=0000 flags=0",
               in_ready, out_valid, diff, borrow, zero, neg);
    end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL midrun_discard: got out_valid after reset want none");
    end
    drive(16'h00FF, 16'h000F, 1'b1);
    wait_valid(cyc);
    e = sb.pop_front();
    n_checks++;
    if (cyc != 16 || diff !== 16'h00F0 || {diff, borrow, zero, neg} !== e) begin
      n_fail++;
      $display("FAIL midrun_followup: got cyc=%0d diff=%h bw=%b z=%b n=%b want cyc=16 diff=00f0 bw=0 z=0 n=0",
               cyc, diff, borrow, zero, neg);
    end
    @(negedge clk);
  endtask
  task automatic test_back_to_back();
    exp_t e;
    int acc[$];
    int got = 0;
    int cyc = 0;
    out_ready = 1'b1;
    a = W'($urandom);
    b = W'($urandom);
    in_valid = 1'b1;
    while (got < 4 && cyc < 200) begin
      if (out_valid === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: got unexpected result diff=%h want none", diff);
        end else begin
          e = sb.pop_front();
          if ({diff, borrow, zero, neg} !== e) begin
            n_fail++;
            $display("FAIL b2b_result%0d: got diff=%h bw=%b z=%b n=%b want diff=%h bw=%b z=%b n=%b",
                     got, diff, borrow, zero, neg, e.d, e.bw, e.z, e.n);
          end
        end
        got++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        push_exp(a, b);
        acc.push_back(cyc);
      end else begin
        a = W'($urandom);
        b = W'($urandom);
        in_valid = acc.size() < 4;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (got != 4 || sb.size() != 0 || acc.size() != 4) begin
      n_fail++;
      $display("FAIL b2b_count: got results=%0d pending=%0d accepts=%0d want 4/0/4", got, sb.size(), acc.size());
    end
    for (int i = 1; i < acc.size(); i++) begin
      n_checks++;
      if (acc[i] - acc[i-1] != 18) begin
        n_fail++;
        $display("FAIL b2b_spacing%0d: got %0d cycles want 18", i, acc[i] - acc[i-1]);
      end
    end
  endtask
  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
